// File: rtl/operand_fetcher.sv
// Operand fetcher: streams DATA_THREADS-wide beats from a preloaded operand
// memory, one beat per READ/SEND pair, with valid/ready backpressure.

module op_lane_mem #(
  parameter int W      = 32,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [W-1:0]      wr_data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [W-1:0]      rd_data_o
);
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] rd_q;

  // Storage is deliberately not reset; only the read register is.
  always_ff @(posedge clock) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  // Read-first: a same-cycle write to rd_addr lands after this sample.
  always_ff @(posedge clock) begin
    if (!reset)       rd_q <= '0;
    else if (rd_en_i) rd_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_q;
endmodule

module operand_fetcher #(
  parameter int BITNESS      = 32,
  parameter int DATA_THREADS = 2,
  parameter int DEPTH        = 16,
  parameter int ADDR_W       = $clog2(DEPTH)
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic [ADDR_W-1:0]                 cmd_base,
  input  logic [ADDR_W:0]                   cmd_count,
  input  logic                              wr_en,
  input  logic [ADDR_W-1:0]                 wr_addr,
  input  logic [BITNESS*DATA_THREADS-1:0]   wr_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [BITNESS*DATA_THREADS-1:0]   out_data,
  output logic                              out_last,
  output logic                              busy,
  output logic                              done
);
  localparam int CNT_W = ADDR_W + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_READ = 2'd1;
  localparam logic [1:0] S_SEND = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic              rd_en;

  logic [DATA_THREADS-1:0][BITNESS-1:0] wr_lanes, rd_lanes;

  assign wr_lanes = wr_data;
  assign out_data = rd_lanes;
  assign rd_en    = (state_q == S_READ);

  for (genvar l = 0; l < DATA_THREADS; l++) begin : g_lane
    op_lane_mem #(.W(BITNESS), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_mem (
      .clock     (clock),
      .reset     (reset),
      .wr_en_i   (wr_en),
      .wr_addr_i (wr_addr),
      .wr_data_i (wr_lanes[l]),
      .rd_en_i   (rd_en),
      .rd_addr_i (ptr_q),
      .rd_data_o (rd_lanes[l])
    );
  end

  assign cmd_ready = (state_q == S_IDLE) && reset;
  assign out_valid = (state_q == S_SEND);
  assign out_last  = (state_q == S_SEND) && (rem_q == CNT_W'(1));
  assign done      = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          ptr_d   = cmd_base;
          rem_d   = cmd_count;
          state_d = (cmd_count == '0) ? S_DONE : S_READ;
        end
      end
      S_READ: state_d = S_SEND;
      S_SEND: begin
        if (out_ready) begin
          // Pointer width is exactly ADDR_W, so DEPTH-1 wraps to 0 for free.
          ptr_d   = ptr_q + ADDR_W'(1);
          rem_d   = rem_q - CNT_W'(1);
          state_d = (rem_q > CNT_W'(1)) ? S_READ : S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
    end
  end
endmodule

// File: tb/tb_operand_fetcher.sv
// Randomized scoreboard bench for operand_fetcher: a cycle-scheduled model
// predicts beats, handshake timing, done and busy from the block's rules.

module tb_operand_fetcher;
  localparam int BITNESS = 32;
  localparam int DT      = 2;
  localparam int DEPTH   = 16;
  localparam int AW      = $clog2(DEPTH);
  localparam int DW      = BITNESS * DT;

  logic          clock = 1'b0;
  logic          reset;
  logic          cmd_valid, cmd_ready;
  logic [AW-1:0] cmd_base;
  logic [AW:0]   cmd_count;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          out_valid, out_ready, out_last, busy, done;
  logic [DW-1:0] out_data;

  operand_fetcher #(.BITNESS(BITNESS), .DATA_THREADS(DT), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_base(cmd_base), .cmd_count(cmd_count), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  typedef struct { logic [DW-1:0] d; logic l; } beat_t;
  beat_t         sb[$];
  logic [DW-1:0] mm [DEPTH];
  int  cyc = 0, rd_at = -1, vld_at = -1, done_at = -1;
  int  ptr_m = 0, rem_m = 0;
  bit  armed = 0, rst_chk = 0, in_send = 0, busy_m = 0;

  always @(negedge clock) begin
    cyc++;
    if (!reset) begin
      armed = 1; rst_chk = 1; sb.delete(); in_send = 0; busy_m = 0;
      rd_at = -1; vld_at = -1; done_at = -1;
    end else if (armed) begin
      if (rst_chk) begin
        chk("post_reset_out_valid", DW'(out_valid), '0);
        chk("post_reset_out_last",  DW'(out_last),  '0);
        chk("post_reset_out_data",  out_data,       '0);
        chk("post_reset_cmd_ready", DW'(cmd_ready), DW'(1));
        rst_chk = 0;
      end
      // The memory is sampled before this cycle's write (read-first).
      if (cyc == rd_at) sb.push_back('{mm[ptr_m], rem_m == 1});
      if (cyc == vld_at) in_send = 1;
      chk("out_valid", DW'(out_valid), DW'(in_send));
      chk("done",      DW'(done),      DW'(cyc == done_at));
      chk("busy",      DW'(busy),      DW'(busy_m));
      chk("cmd_ready", DW'(cmd_ready), DW'(!busy_m));
      if (in_send && out_valid) begin
        if (sb.size() == 0) begin
          chk("beat_expected", DW'(1), '0);
        end else begin
          chk("out_data", out_data, sb[0].d);
          chk("out_last", DW'(out_last), DW'(sb[0].l));
          if (out_ready) begin
            void'(sb.pop_front());
            ptr_m = (ptr_m + 1) % DEPTH;
            rem_m--;
            in_send = 0;
            if (rem_m > 0) begin rd_at = cyc + 1; vld_at = cyc + 2; end
            else done_at = cyc + 1;
          end
        end
      end
      if (cyc == done_at) busy_m = 0;
      else if (cmd_valid && !busy_m) begin
        busy_m = 1;
        ptr_m  = int'(cmd_base);
        rem_m  = int'(cmd_count);
        if (rem_m == 0) done_at = cyc + 1;
        else begin rd_at = cyc + 1; vld_at = cyc + 2; end
      end
    end
    if (wr_en) mm[int'(wr_addr)] = wr_data;
  end

  // ---------------- out_ready driver ----------------
  int            rdy_mode = 0;
  int            stall_cnt = 0;
  logic [DW-1:0] stall_word = '0;

  always @(posedge clock) begin
    #1;
    case (rdy_mode)
      0: out_ready = 1'b1;
      1: out_ready = 1'($urandom_range(0, 1));
      default: begin
        if (out_valid && out_data == stall_word && stall_cnt < 5) begin
          out_ready = 1'b0;
          stall_cnt++;
        end else out_ready = 1'b1;
      end
    endcase
    if (rdy_mode != 2) stall_cnt = 0;
  end

  // ---------------- stimulus ----------------
  task automatic wr(input int a, input logic [DW-1:0] d);
    @(posedge clock); #1;
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = d;
  endtask

  task automatic wr_stop();
    @(posedge clock); #1;
    wr_en = 1'b0;
  endtask

  task automatic run_cmd(input int b, input int c);
    int n;
    @(posedge clock); #1;
    cmd_base = AW'(b); cmd_count = (AW+1)'(c); cmd_valid = 1'b1;
    @(posedge clock); #1;
    cmd_valid = 1'b0;
    n = 0;
    do begin @(negedge clock); n++; end while (!done && n < 600);
    if (n >= 600) chk("cmd_timeout", DW'(n), '0);
    @(negedge clock);
  endtask

  bit rnd_done = 0;

  initial begin
    int n, v;
    reset = 1'b0; cmd_valid = 1'b0; cmd_base = '0; cmd_count = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; out_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;

    for (int k = 0; k < DEPTH; k++) wr(k, 64'h3F800000_40000000 + 64'(k));
    wr_stop();

    run_cmd(0, 4);        // basic in-order stream
    run_cmd(14, 4);       // wrap-around 14,15,0,1
    run_cmd(5, 0);        // zero-beat command
    run_cmd(0, 16);       // whole memory

    // Long stall on beat 2 with a stray command while busy.
    rdy_mode = 2; stall_word = 64'h3F800000_40000001;
    fork
      run_cmd(0, 4);
      begin
        repeat (6) @(posedge clock);
        #1 cmd_base = AW'(7); cmd_count = (AW+1)'(3); cmd_valid = 1'b1;
        @(posedge clock); #1 cmd_valid = 1'b0;
      end
    join
    rdy_mode = 0;

    // Reset during beat 2 aborts the command without a done pulse.
    @(posedge clock); #1;
    cmd_base = '0; cmd_count = (AW+1)'(4); cmd_valid = 1'b1;
    @(posedge clock); #1 cmd_valid = 1'b0;
    n = 0; v = 0;
    while (v < 2 && n < 100) begin
      if (out_valid) v++;
      if (v < 2) begin @(posedge clock); #1; n++; end
    end
    if (n >= 100) chk("beat2_timeout", DW'(n), '0);
    reset = 1'b0;
    @(posedge clock); #1 reset = 1'b1;
    run_cmd(2, 3);

    // Read-first: rewrite entry 9 in the cycle the block reads it.
    @(posedge clock); #1;
    cmd_base = AW'(9); cmd_count = (AW+1)'(1); cmd_valid = 1'b1;
    @(posedge clock); #1;
    cmd_valid = 1'b0; wr_en = 1'b1; wr_addr = AW'(9); wr_data = 64'hDEAD_BEEF_0000_0009;
    @(posedge clock); #1 wr_en = 1'b0;
    repeat (4) @(negedge clock);
    run_cmd(9, 1);

    // Randomized commands, backpressure and concurrent preload writes.
    rdy_mode = 1;
    fork
      begin
        for (int i = 0; i < 25; i++)
          run_cmd(int'($urandom_range(0, DEPTH-1)), int'($urandom_range(0, DEPTH)));
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clock); #1;
          wr_en   = 1'($urandom_range(0, 1));
          wr_addr = AW'($urandom_range(0, DEPTH-1));
          wr_data = {$urandom, $urandom};
        end
        wr_en = 1'b0;
      end
    join
    rdy_mode = 0;
    repeat (3) @(negedge clock);
    chk("scoreboard_drained", DW'(sb.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/operand_fetcher.md
OPERAND_FETCHER -- requirements
Module: operand_fetcher

Interface
REQ-001 Parameter BITNESS, default 32, width of one floating number.
REQ-002 Parameter DATA_THREADS, default 2, numbers delivered in parallel per beat.
REQ-003 Parameter DEPTH, default 16, number of operand-memory entries (power of two); ADDR_W = clog2(DEPTH).
REQ-004 The block SHALL use one clock; reset is synchronous and active-low.
REQ-005 clock  input  1  rising-edge clock.
REQ-006 reset  input  1  synchronous, active-low reset.
REQ-007 cmd_valid  input  1  command from control unit present.
REQ-008 cmd_ready  output  1  block accepts a command.
REQ-009 cmd_base  input  ADDR_W  first entry to read.
REQ-010 cmd_count  input  ADDR_W+1  number of beats, 0..DEPTH.
REQ-011 wr_en  input  1  preload write strobe.
REQ-012 wr_addr  input  ADDR_W  preload entry.
REQ-013 wr_data  input  BITNESS*DATA_THREADS  preload data; thread i in bits [i*BITNESS +: BITNESS].
REQ-014 out_valid  output  1  out_data valid.
REQ-015 out_ready  input  1  control unit accepts beat.
REQ-016 out_data  output  BITNESS*DATA_THREADS  operand beat, same lane packing as wr_data.
REQ-017 out_last  output  1  current beat is the final beat of the command.
REQ-018 busy  output  1  command in progress (state not IDLE).
REQ-019 done  output  1  one-cycle pulse on command completion.

Function
REQ-020 Storage SHALL be DEPTH entries of BITNESS*DATA_THREADS bits, with registered (one-cycle) read; contents are not reset.
REQ-021 FSM states SHALL be IDLE, READ, SEND, DONE.
REQ-022 cmd_ready SHALL equal (state==IDLE) AND reset; a command is accepted on cmd_valid && cmd_ready, latching base into a pointer and count into a remaining counter.
REQ-023 IDLE -> READ on acceptance with cmd_count>0; IDLE -> DONE on acceptance with cmd_count==0 (no beats emitted).
REQ-024 READ: memory read at pointer; next state SEND.
REQ-025 SEND: out_valid=1, out_data=registered read value, out_last=1 iff remaining==1.
REQ-026 While out_valid && !out_ready, out_data, out_last, and state SHALL hold stable.
REQ-027 On out_valid && out_ready: pointer increments modulo DEPTH (DEPTH-1 wraps to 0), remaining decrements; next state READ if remaining>1, else DONE.
REQ-028 DONE: done=1 and busy=1 for exactly one cycle; next state IDLE.
REQ-029 Latency: command accepted in cycle T gives first out_valid in T+2; each subsequent beat appears 2 cycles after the previous acceptance; last acceptance in S gives done in S+1 and cmd_ready in S+2.
REQ-030 Preload writes SHALL be honoured in every state; a write and a read to the same entry in the same cycle returns the old data (read-first).
REQ-031 cmd_valid outside IDLE SHALL be ignored (no effect on state or counters).
REQ-032 out_valid, out_last, done SHALL be 0 in IDLE and READ; out_data holds its last value outside SEND.

Reset
REQ-033 While reset==0 at a rising edge: state<=IDLE, pointer<=0, remaining<=0, out_valid=0, out_last=0, done=0, busy=0, cmd_ready=0, out_data<=0.
REQ-034 Reset asserted mid-command SHALL abort it with no done pulse; the first cycle after release SHALL show cmd_ready=1.

Verification
REQ-035 Preload entries 0..3 with 0x3F800000_40000000+k; cmd base=0 count=4, out_ready=1 -> 4 beats in order, out_last on 4th only, out_valid at T+2, T+4, T+6, T+8, done at T+9.
REQ-036 DEPTH=16, base=14 count=4 -> beats from entries 14,15,0,1 (wrap-around).
REQ-037 cmd_count=0 -> no out_valid, done=1 at T+1, cmd_ready=1 at T+2.
REQ-038 out_ready held 0 for 5 cycles on beat 2 -> out_data/out_last stable, no beat lost or duplicated; cmd_valid pulsed while busy is ignored.
REQ-039 cmd_count=16 (full memory) -> 16 beats, all entries once, out_last on 16th.
REQ-040 reset=0 during second beat of a 4-beat command -> all outputs 0 next cycle, no done; after release a new command completes normally.
